// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle add/sub/logic/shift plus an optional shift-add multiplier.
// Optional feature macro: SEQ_ALU_MUL_EN (compiles in the multiplier, the MUL state and the
// accumulator). Without it, code 7 is a single-cycle pass of x.
module seq_alu #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned MUL_CYCLES = WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [2:0]       funsel,
    input  logic             start,
    input  logic             sflag,
    output logic [WIDTH-1:0] z,
    output logic [3:0]       status,
    output logic             busy,
    output logic             done
);

    localparam int unsigned Msb = WIDTH - 1;

    if (WIDTH < 4 || WIDTH > 32 || MUL_CYCLES != WIDTH) begin : g_param_check
        $error("seq_alu: WIDTH must be 4..32 and MUL_CYCLES must equal WIDTH");
    end

`ifdef SEQ_ALU_MUL_EN
    typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;
    localparam int unsigned CntW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
`else
    typedef enum logic [0:0] {StIdle, StDone} state_e;
`endif

    state_e           state_q, state_d;
    logic [WIDTH-1:0] z_q, z_d;
    logic [3:0]       status_q, status_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_v;
    logic [WIDTH:0]   sum;

    // Status packing: [0]=C, [1]=Z, [2]=N, [3]=V
    function automatic logic [3:0] flags(input logic [WIDTH-1:0] r, input logic c,
                                         input logic v);
        return {v, r[Msb], ~|r, c};
    endfunction

`ifdef SEQ_ALU_MUL_EN
    logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, acc_sum;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               sflag_q, sflag_d;

    // One shift-add step: add the shifted multiplicand when the current multiplier bit is set
    always_comb begin
        acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
    end
`endif

    // Single-cycle datapath, evaluated straight from the bus operands at acceptance
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        sum     = '0;
        unique case (funsel)
            3'd0: begin
                sum     = {1'b0, x} + {1'b0, y};
                alu_res = sum[Msb:0];
                alu_c   = sum[WIDTH];
                alu_v   = (x[Msb] == y[Msb]) && (sum[Msb] != x[Msb]);
            end
            3'd1: begin
                sum     = {1'b0, x} + {1'b0, ~y} + {{WIDTH{1'b0}}, 1'b1};
                alu_res = sum[Msb:0];
                alu_c   = sum[WIDTH];
                alu_v   = (x[Msb] != y[Msb]) && (sum[Msb] != x[Msb]);
            end
            3'd2: alu_res = x & y;
            3'd3: alu_res = x | y;
            3'd4: alu_res = x ^ y;
            3'd5: alu_res = ~x;
            3'd6: begin
                alu_res = {x[Msb-1:0], 1'b0};
                alu_c   = x[Msb];
            end
            3'd7: alu_res = x;
            default: ;
        endcase
    end

    // Next-state and datapath control; DONE accepts a new start like IDLE (back-to-back ops)
    always_comb begin
        state_d  = state_q;
        z_d      = z_q;
        status_d = status_q;
        done_d   = 1'b0;
`ifdef SEQ_ALU_MUL_EN
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        sflag_d  = sflag_q;
`endif
        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (start) begin
`ifdef SEQ_ALU_MUL_EN
                    if (funsel == 3'd7) begin
                        state_d  = StMul;
                        acc_d    = '0;
                        mcand_d  = {{WIDTH{1'b0}}, y};
                        mplier_d = x;
                        cnt_d    = '0;
                        sflag_d  = sflag;
                    end else begin
`else
                    begin
`endif
                        state_d = StDone;
                        z_d     = alu_res;
                        done_d  = 1'b1;
                        if (sflag) status_d = flags(alu_res, alu_c, alu_v);
                    end
                end
            end
`ifdef SEQ_ALU_MUL_EN
            StMul: begin
                acc_d    = acc_sum;
                mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
                mplier_d = {1'b0, mplier_q[Msb:1]};
                cnt_d    = cnt_q + 1'b1;
                // Last iteration writes the result directly so busy and done swap on one edge
                if (cnt_q == CntW'(MUL_CYCLES - 1)) begin
                    state_d = StDone;
                    z_d     = acc_sum[Msb:0];
                    done_d  = 1'b1;
                    if (sflag_q) status_d = flags(acc_sum[Msb:0], |acc_sum[2*WIDTH-1:WIDTH], 1'b0);
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    // Control and result registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            z_q      <= '0;
            status_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            z_q      <= z_d;
            status_q <= status_d;
            done_q   <= done_d;
        end
    end

`ifdef SEQ_ALU_MUL_EN
    // Multiplier operand and accumulator registers
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            sflag_q  <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            sflag_q  <= sflag_d;
        end
    end

    assign busy = (state_q == StMul);
`else
    assign busy = 1'b0;
`endif

    assign z      = z_q;
    assign status = status_q;
    assign done   = done_q;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: the driver pushes model results, the monitor pops on done.
module tb_seq_alu;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset, start, sflag, busy, done;
    logic [W-1:0] x, y, z;
    logic [2:0]   funsel;
    logic [3:0]   status;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .x      (x),
        .y      (y),
        .funsel (funsel),
        .start  (start),
        .sflag  (sflag),
        .z      (z),
        .status (status),
        .busy   (busy),
        .done   (done)
    );

    typedef struct {
        logic [W-1:0] z;
        logic [3:0]   st;
        int           due;
    } exp_t;

    exp_t       q[$];
    exp_t       mon_e;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         busy_lo = -1;
    int         busy_hi = -2;
    logic [3:0] model_st = 4'h0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer arithmetic on the operation definitions
    function automatic void model(input int op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output bit c, output bit v);
        longint m, ua, ub, full, sa, sb, ss;
        m  = longint'(1) << W;
        ua = longint'(a);
        ub = longint'(b);
        sa = (ua >= m / 2) ? ua - m : ua;
        sb = (ub >= m / 2) ? ub - m : ub;
        c  = 1'b0;
        v  = 1'b0;
        r  = '0;
        case (op)
            0: begin
                full = ua + ub; r = W'(full); c = (full >= m);
                ss = sa + sb; v = (ss >= m / 2) || (ss < -(m / 2));
            end
            1: begin
                full = ua + (m - 1 - ub) + 1; r = W'(full); c = (full >= m);
                ss = sa - sb; v = (ss >= m / 2) || (ss < -(m / 2));
            end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = ~a;
            6: begin r = W'(ua * 2); c = (ua >= m / 2); end
`ifdef SEQ_ALU_MUL_EN
            7: begin full = ua * ub; r = W'(full); c = ((full >> W) != 0); end
`else
            7: r = a;
`endif
            default: r = '0;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble();
        x      = W'($urandom);
        y      = W'($urandom);
        funsel = 3'($urandom);
        sflag  = 1'($urandom);
    endtask

    // Issue one operation; for a multiply, stay for its busy window and pulse ignored starts
    task automatic issue(input int op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit sf);
        logic [W-1:0] r;
        bit           c, v;
        int           acc_edge;
        exp_t         e;
        x = a; y = b; funsel = 3'(op); sflag = sf; start = 1'b1;
        step();
        start = 1'b0;
        acc_edge = cyc;
        scramble();
        model(op, a, b, r, c, v);
        if (sf) model_st = {v, r[W-1], (r == '0), c};
        e.z   = r;
        e.st  = model_st;
        e.due = acc_edge;
`ifdef SEQ_ALU_MUL_EN
        if (op == 7) begin
            e.due   = acc_edge + W;
            busy_lo = acc_edge;
            busy_hi = acc_edge + W - 1;
        end
`endif
        q.push_back(e);
`ifdef SEQ_ALU_MUL_EN
        if (op == 7) begin
            for (int k = 0; k < W; k++) begin
                if ($urandom_range(0, 2) == 0) begin
                    scramble();
                    start = 1'b1;
                end
                step();
                start = 1'b0;
            end
        end
`endif
    endtask

    // Monitor: busy against the expected window, results against the scoreboard
    always @(negedge clk) begin
        check("busy", {63'd0, busy}, {63'd0, (cyc >= busy_lo && cyc <= busy_hi)});
        if (done === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=1 required=0 z=%0h (edge %0d)", z, cyc);
            end else begin
                mon_e = q.pop_front();
                check("z", 64'(z), 64'(mon_e.z));
                check("status", 64'(status), 64'(mon_e.st));
                check("done_edge", 64'(cyc), 64'(mon_e.due));
            end
        end else if (q.size() > 0 && q[0].due < cyc) begin
            mon_e = q.pop_front();
            check("missing_done", 64'(cyc), 64'(mon_e.due));
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; start = 1'b0; x = '0; y = '0; funsel = 3'd0; sflag = 1'b0;
        step();
        step();
        reset = 1'b0;
        check("rst_z", 64'(z), 64'h0);
        check("rst_status", 64'(status), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_done", 64'(done), 64'h0);

        // Signed overflow on add
        issue(0, 16'h7FFF, 16'h0001, 1'b1);
        check("add_ovf_z", 64'(z), 64'h8000);
        check("add_ovf_st", 64'(status), 64'hC);

        // Subtract to zero, then with sflag low status must hold
        issue(1, 16'h0005, 16'h0005, 1'b1);
        check("sub_zero_st", 64'(status), 64'h3);
        issue(1, 16'h0003, 16'h0005, 1'b0);
        check("sub_nosf_z", 64'(z), 64'hFFFE);
        check("sub_nosf_st", 64'(status), 64'h3);

        // Back-to-back single-cycle ops
        issue(2, 16'hF0F0, 16'h0FF0, 1'b1);
        check("b2b_and_z", 64'(z), 64'h00F0);
        issue(6, 16'h8001, 16'h0000, 1'b1);
        check("b2b_shl_z", 64'(z), 64'h0002);
        check("b2b_shl_st", 64'(status), 64'h1);
        check("b2b_done", 64'(done), 64'h1);

`ifdef SEQ_ALU_MUL_EN
        // Multiply with product overflowing into the high half
        issue(7, 16'h0100, 16'h0100, 1'b1);
        check("mul_ovf_z", 64'(z), 64'h0000);
        check("mul_ovf_st", 64'(status), 64'h3);

        // Reset mid-multiply, with a coincident start that must be dropped
        x = 16'h0003; y = 16'h0007; funsel = 3'd7; sflag = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        busy_lo = cyc;
        busy_hi = cyc + W - 1;
        repeat (4) step();
        busy_hi = cyc;
        reset = 1'b1; start = 1'b1; funsel = 3'd0;
        step();
        reset = 1'b0; start = 1'b0;
        model_st = 4'h0;
        check("mulrst_z", 64'(z), 64'h0);
        check("mulrst_status", 64'(status), 64'h0);
        check("mulrst_busy", 64'(busy), 64'h0);
        check("mulrst_done", 64'(done), 64'h0);
        repeat (W + 2) step();
        issue(7, 16'h0003, 16'h0007, 1'b1);
        check("mul_after_rst_z", 64'(z), 64'h0015);
`else
        // Code 7 passes x through in one cycle
        issue(7, 16'h1234, 16'h5555, 1'b1);
        check("pass_z", 64'(z), 64'h1234);
        check("pass_st", 64'(status), 64'h0);
`endif

        // Reset with a coincident start between operations
        reset = 1'b1; start = 1'b1; funsel = 3'd3; x = 16'hFFFF;
        step();
        reset = 1'b0; start = 1'b0;
        model_st = 4'h0;
        check("rst2_z", 64'(z), 64'h0);
        check("rst2_done", 64'(done), 64'h0);
        step();
        check("rst2_idle_done", 64'(done), 64'h0);

        // Randomised traffic with random gaps and corner-biased operands
        for (int n = 0; n < 200; n++) begin
            logic [W-1:0] a, b;
            a = W'($urandom);
            b = W'($urandom);
            if ($urandom_range(0, 5) == 0) a = ($urandom_range(0, 1) == 1) ? 16'h7FFF : 16'h8000;
            if ($urandom_range(0, 5) == 0) b = ($urandom_range(0, 1) == 1) ? 16'hFFFF : 16'h0000;
            issue($urandom_range(0, 7), a, b, 1'($urandom));
            repeat ($urandom_range(0, 2)) step();
        end

        repeat (W + 4) step();
        check("queue_empty", 64'(q.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 16: operand, result and internal datapath width in bits, legal range 4..32.
REQ-002 Parameter MUL_CYCLES, default WIDTH: iteration count of the shift-add multiplier, fixed equal to WIDTH.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 x  input  WIDTH  operand A, bus side.
REQ-006 y  input  WIDTH  operand B, from the Y holding register.
REQ-007 funsel  input  3  operation select, sampled only when an operation is accepted.
REQ-008 start  input  1  request to begin an operation.
REQ-009 sflag  input  1  when high at acceptance, status is updated on completion.
REQ-010 z  output  WIDTH  registered result.
REQ-011 status  output  4  registered flags: [0]=C, [1]=Z, [2]=N, [3]=V.
REQ-012 busy  output  1  high while an operation is in progress.
REQ-013 done  output  1  one-cycle pulse in the cycle z holds a new result.

Function
REQ-014 Acceptance: start=1 with busy=0 latches x, y, funsel and sflag; start with busy=1 is ignored.
REQ-015 funsel codes: 0 x+y; 1 x-y, computed as x+~y+1; 2 x&y; 3 x|y; 4 x^y; 5 ~x; 6 x<<1; 7 x*y, low WIDTH bits.
REQ-016 Codes 0-6 are single-cycle: z and done are valid on the edge after acceptance; busy stays 0.
REQ-017 State machine IDLE -> MUL on acceptance of code 7; MUL -> DONE after WIDTH iterations; DONE -> IDLE unconditionally next cycle.
REQ-018 Code 7 timing: busy=1 from the edge after acceptance for WIDTH cycles; z and done are valid at edge WIDTH+1 after acceptance; busy falls in the same cycle.
REQ-019 MUL iteration i adds y<<i to a 2*WIDTH accumulator when x[i]=1; z and status are unchanged until completion.
REQ-020 C: carry-out for add; carry-out of x+~y+1 for subtract (1 = no borrow); x[WIDTH-1] for shift; 1 if the product's high WIDTH bits are nonzero for multiply; 0 for logic ops.
REQ-021 V: signed overflow for add and subtract; 0 for all other codes.
REQ-022 Z is 1 when z equals 0. N equals z[WIDTH-1].
REQ-023 status is written only at completion and only if the captured sflag=1; otherwise it holds.
REQ-024 done and start coinciding in the same cycle: a new operation is accepted when busy=0, allowing back-to-back single-cycle ops at one per cycle.
REQ-025 Inputs changing while busy=1 have no effect on the operation in flight.

Reset
REQ-026 On reset: z=0, status=0, busy=0, done=0, FSM=IDLE, accumulator cleared.
REQ-027 Reset during MUL aborts the operation with no done pulse; start in the same cycle as reset is ignored.

Configuration
REQ-028 Macro SEQ_ALU_MUL_EN, when defined, compiles in the multiplier, the MUL state and the accumulator.
REQ-029 With SEQ_ALU_MUL_EN undefined: code 7 behaves as a single-cycle pass of x (z=x, C=0, V=0, Z/N per REQ-022), busy is tied to 0, and the FSM reduces to IDLE/DONE.

Verification
REQ-030 WIDTH=16; x=0x7FFF, y=0x0001, funsel=0, sflag=1, start pulse -> next cycle z=0x8000, done=1, status C=0 Z=0 N=1 V=1.
REQ-031 x=0x0005, y=0x0005, funsel=1, sflag=1 -> z=0x0000, status C=1 Z=1 N=0 V=0; repeat with sflag=0 -> status unchanged.
REQ-032 Macro defined; x=0x0100, y=0x0100, funsel=7 -> busy high 16 cycles, start pulses during busy ignored, then z=0x0000 with C=1 and one done pulse.
REQ-033 Macro defined; x=0x0003, y=0x0007, funsel=7; assert reset at cycle 5 of busy -> no done pulse, all outputs 0, next start accepted normally.
REQ-034 Back-to-back starts on consecutive cycles: funsel=2 (0xF0F0&0x0FF0) then 6 (0x8001) -> z=0x00F0, then z=0x0002 with C=1; done high on both cycles.
REQ-035 Macro undefined; funsel=7, x=0x1234 -> next cycle z=0x1234, busy never asserted.
